inst_cache: RTL and testbench

//  Direct-mapped, read-only instruction cache. It sits between the instruction unit (IU) and the memory controller (MC).
//  - Serves the IU's current fetch PC combinationally on a hit.
//  - On a miss, fills one whole line from the MC, one 32-bit word at a time.
//  - No write path. Self-modifying code is not supported.

---
 rtl/inst_cache_pkg.sv | 14 +
 rtl/inst_cache.sv | 142 ++++++++++++++
 tb/tb_inst_cache.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_cache_pkg.sv
// Shared geometry defaults and FSM encoding for the direct-mapped instruction cache.
package inst_cache_pkg;

    localparam int unsigned IC_INDEX_WIDTH  = 6;
    localparam int unsigned IC_OFFSET_WIDTH = 2;
    localparam int unsigned IC_WORD_WIDTH   = 32;
    localparam int unsigned IC_ADDR_WIDTH   = 32;

    typedef enum logic {
        IC_IDLE  = 1'b0,
        IC_FETCH = 1'b1
    } ic_state_e;

endpackage

// File: rtl/inst_cache.sv
// Direct-mapped read-only instruction cache: combinational hit path to the IU,
// word-by-word line refill from the MC on a miss.
module inst_cache
    import inst_cache_pkg::*;
#(
    parameter int unsigned INDEX_WIDTH  = IC_INDEX_WIDTH,
    parameter int unsigned OFFSET_WIDTH = IC_OFFSET_WIDTH
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,
    input  logic                     clr_in,
    input  logic [IC_ADDR_WIDTH-1:0] iu_to_ic_pc,
    output logic                     ic_to_iu_rdy,
    output logic [IC_WORD_WIDTH-1:0] ic_to_iu_inst,
    output logic                     ic_to_mc_en,
    output logic [IC_ADDR_WIDTH-1:0] ic_to_mc_addr,
    input  logic                     mc_to_ic_rdy,
    input  logic [IC_WORD_WIDTH-1:0] mc_to_ic_data
);

    localparam int unsigned BASE_LSB   = OFFSET_WIDTH + 2;
    localparam int unsigned TAG_WIDTH  = IC_ADDR_WIDTH - BASE_LSB - INDEX_WIDTH;
    localparam int unsigned LINES      = 1 << INDEX_WIDTH;
    localparam int unsigned LINE_WORDS = 1 << OFFSET_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_WORD = OFFSET_WIDTH'(LINE_WORDS - 1);

    typedef logic [LINE_WORDS-1:0][IC_WORD_WIDTH-1:0] line_t;

    // Storage arrays; only the valid bits are reset
    logic [LINES-1:0]     valid_q, valid_d;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    line_t                data_q [LINES];

    ic_state_e                state_q, state_d;
    logic [OFFSET_WIDTH-1:0]  cnt_q, cnt_d;
    logic                     mc_en_q, mc_en_d;
    logic [IC_ADDR_WIDTH-1:0] mc_addr_q, mc_addr_d;
    logic [INDEX_WIDTH-1:0]   fill_idx_q, fill_idx_d;
    logic [TAG_WIDTH-1:0]     fill_tag_q, fill_tag_d;
    line_t                    fill_buf_q, fill_buf_d;

    logic                     line_wr_en;
    line_t                    line_wr_data;

    logic [INDEX_WIDTH-1:0]   pc_idx;
    logic [TAG_WIDTH-1:0]     pc_tag;
    logic [OFFSET_WIDTH-1:0]  pc_word;
    logic                     hit;
    logic                     lookup_en;
    logic                     unused_pc_bits;

    assign pc_idx         = iu_to_ic_pc[BASE_LSB +: INDEX_WIDTH];
    assign pc_tag         = iu_to_ic_pc[IC_ADDR_WIDTH-1 -: TAG_WIDTH];
    assign pc_word        = iu_to_ic_pc[2 +: OFFSET_WIDTH];
    assign unused_pc_bits = ^iu_to_ic_pc[1:0];

    assign hit       = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
    assign lookup_en = rdy_in && !clr_in && !rst_in;

    assign ic_to_iu_rdy  = hit && lookup_en;
    assign ic_to_iu_inst = ic_to_iu_rdy ? data_q[pc_idx][pc_word] : '0;
    assign ic_to_mc_en   = mc_en_q;
    assign ic_to_mc_addr = mc_addr_q;

    // Miss detection and refill sequencing; everything holds while rdy_in is low
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        mc_en_d      = mc_en_q;
        mc_addr_d    = mc_addr_q;
        fill_idx_d   = fill_idx_q;
        fill_tag_d   = fill_tag_q;
        fill_buf_d   = fill_buf_q;
        valid_d      = valid_q;
        line_wr_en   = 1'b0;
        line_wr_data = fill_buf_q;
        line_wr_data[LAST_WORD] = mc_to_ic_data;

        if (rdy_in) begin
            case (state_q)
                IC_IDLE: begin
                    if (!hit && !clr_in) begin
                        cnt_d      = '0;
                        fill_idx_d = pc_idx;
                        fill_tag_d = pc_tag;
                        mc_en_d    = 1'b1;
                        mc_addr_d  = {pc_tag, pc_idx, BASE_LSB'(0)};
                        state_d    = IC_FETCH;
                    end
                end
                IC_FETCH: begin
                    // clr_in is ignored here: the MC transfer always runs to completion
                    if (mc_to_ic_rdy) begin
                        fill_buf_d[cnt_q] = mc_to_ic_data;
                        if (cnt_q != LAST_WORD) begin
                            cnt_d     = cnt_q + OFFSET_WIDTH'(1);
                            mc_addr_d = mc_addr_q + IC_ADDR_WIDTH'(4);
                        end else begin
                            line_wr_en          = 1'b1;
                            valid_d[fill_idx_q] = 1'b1;
                            mc_en_d             = 1'b0;
                            state_d             = IC_IDLE;
                        end
                    end
                end
                default: state_d = IC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IC_IDLE;
            cnt_q      <= '0;
            mc_en_q    <= 1'b0;
            mc_addr_q  <= '0;
            fill_idx_q <= '0;
            fill_tag_q <= '0;
            fill_buf_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mc_en_q    <= mc_en_d;
            mc_addr_q  <= mc_addr_d;
            fill_idx_q <= fill_idx_d;
            fill_tag_q <= fill_tag_d;
            fill_buf_q <= fill_buf_d;
            valid_q    <= valid_d;
        end
    end

    // Tag and data arrays change only when a complete line lands
    always_ff @(posedge clk_in) begin
        if (line_wr_en) begin
            data_q[fill_idx_q] <= line_wr_data;
            tag_q[fill_idx_q]  <= fill_tag_q;
        end
    end

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: a scripted MC returns words and every
// observation is compared against hand-computed values.
module tb_inst_cache;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        clr_in;
    logic [31:0] iu_to_ic_pc;
    logic        ic_to_iu_rdy;
    logic [31:0] ic_to_iu_inst;
    logic        ic_to_mc_en;
    logic [31:0] ic_to_mc_addr;
    logic        mc_to_ic_rdy;
    logic [31:0] mc_to_ic_data;

    int errors = 0;
    int checks = 0;

    always #5 clk_in = ~clk_in;

    inst_cache dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .rdy_in        (rdy_in),
        .clr_in        (clr_in),
        .iu_to_ic_pc   (iu_to_ic_pc),
        .ic_to_iu_rdy  (ic_to_iu_rdy),
        .ic_to_iu_inst (ic_to_iu_inst),
        .ic_to_mc_en   (ic_to_mc_en),
        .ic_to_mc_addr (ic_to_mc_addr),
        .mc_to_ic_rdy  (mc_to_ic_rdy),
        .mc_to_ic_data (mc_to_ic_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Present a missing PC in IDLE and confirm the request for its line base
    task automatic start_miss(input logic [31:0] pc);
        iu_to_ic_pc = pc;
        #1;
        check_val("miss_rdy_low", 32'(ic_to_iu_rdy), 32'd0);
        tick();
        check_val("miss_en", 32'(ic_to_mc_en), 32'd1);
        check_val("miss_addr", ic_to_mc_addr, pc & 32'hFFFF_FFF0);
    endtask

    // Return nwords of a line; optional 3-cycle rdy_in stall before word stall_at
    task automatic fill_line(input logic [31:0] base, input logic [31:0] pat,
                             input bit use_addr, input int stall_at, input int nwords);
        for (int w = 0; w < nwords; w++) begin
            logic [31:0] a;
            a = base + 32'(4 * w);
            check_val("fill_en", 32'(ic_to_mc_en), 32'd1);
            check_val("fill_addr", ic_to_mc_addr, a);
            if (w == stall_at) begin
                rdy_in = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    tick();
                    check_val("stall_en", 32'(ic_to_mc_en), 32'd1);
                    check_val("stall_addr", ic_to_mc_addr, a);
                    check_val("stall_iu_rdy", 32'(ic_to_iu_rdy), 32'd0);
                end
                rdy_in = 1'b1;
            end
            mc_to_ic_rdy  = 1'b1;
            mc_to_ic_data = use_addr ? (pat | a) : pat;
            tick();
            mc_to_ic_rdy  = 1'b0;
            mc_to_ic_data = '0;
            if (w < nwords - 1) begin
                tick();
            end
        end
        if (nwords == 4) begin
            check_val("fill_done_en", 32'(ic_to_mc_en), 32'd0);
        end
    endtask

    task automatic expect_hit(input logic [31:0] pc, input logic [31:0] inst);
        iu_to_ic_pc = pc;
        #1;
        check_val("hit_rdy", 32'(ic_to_iu_rdy), 32'd1);
        check_val("hit_inst", ic_to_iu_inst, inst);
    endtask

    task automatic expect_miss(input logic [31:0] pc);
        iu_to_ic_pc = pc;
        #1;
        check_val("lookup_miss", 32'(ic_to_iu_rdy), 32'd0);
        check_val("lookup_miss_inst", ic_to_iu_inst, 32'd0);
    endtask

    initial begin
        rst_in        = 1'b1;
        rdy_in        = 1'b1;
        clr_in        = 1'b0;
        iu_to_ic_pc   = 32'h0;
        mc_to_ic_rdy  = 1'b0;
        mc_to_ic_data = '0;
        #1;
        check_val("rst_iu_rdy", 32'(ic_to_iu_rdy), 32'd0);
        check_val("rst_iu_inst", ic_to_iu_inst, 32'd0);
        check_val("rst_mc_en", 32'(ic_to_mc_en), 32'd0);
        check_val("rst_mc_addr", ic_to_mc_addr, 32'd0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;

        // 1: cold miss on line 0, constant data
        start_miss(32'h0);
        fill_line(32'h0, 32'h0000_0013, 1'b0, -1, 4);
        expect_hit(32'h0, 32'h0000_0013);

        // 2: same line, different word, no new request
        expect_hit(32'h8, 32'h0000_0013);
        tick();
        check_val("hit_no_req", 32'(ic_to_mc_en), 32'd0);

        // 3: conflict at index 0, then eviction back
        start_miss(32'h1000);
        fill_line(32'h1000, 32'hB000_0000, 1'b1, -1, 4);
        expect_hit(32'h1008, 32'hB000_1008);
        expect_miss(32'h4);
        start_miss(32'h0);
        fill_line(32'h0, 32'hC000_0000, 1'b1, -1, 4);
        expect_hit(32'hC, 32'hC000_000C);
        expect_hit(32'h4, 32'hC000_0004);
        expect_miss(32'h1004);

        // 4: hit-under-miss while line 0x40 fills
        start_miss(32'h40);
        expect_hit(32'h4, 32'hC000_0004);
        fill_line(32'h40, 32'hD000_0000, 1'b1, -1, 4);
        expect_hit(32'h44, 32'hD000_0044);

        // 5: clr in IDLE suppresses hit and miss start
        iu_to_ic_pc = 32'h4;
        clr_in = 1'b1;
        #1;
        check_val("clr_idle_rdy", 32'(ic_to_iu_rdy), 32'd0);
        check_val("clr_idle_inst", ic_to_iu_inst, 32'd0);
        iu_to_ic_pc = 32'h200;
        tick();
        check_val("clr_no_miss", 32'(ic_to_mc_en), 32'd0);
        clr_in = 1'b0;
        // clr mid-fill with redirect: old fill completes, then new miss
        start_miss(32'h100);
        clr_in = 1'b1;
        iu_to_ic_pc = 32'h80;
        tick();
        clr_in = 1'b0;
        check_val("clr_fetch_addr", ic_to_mc_addr, 32'h100);
        fill_line(32'h100, 32'hE000_0000, 1'b1, -1, 4);
        check_val("redirect_rdy", 32'(ic_to_iu_rdy), 32'd0);
        tick();
        check_val("redirect_en", 32'(ic_to_mc_en), 32'd1);
        check_val("redirect_addr", ic_to_mc_addr, 32'h80);
        fill_line(32'h80, 32'hF000_0000, 1'b1, -1, 4);
        expect_hit(32'h108, 32'hE000_0108);
        expect_hit(32'h8C, 32'hF000_008C);

        // 6: async reset mid-fill
        start_miss(32'h300);
        fill_line(32'h300, 32'h5000_0000, 1'b1, -1, 2);
        #2;
        rst_in = 1'b1;
        #1;
        check_val("arst_en", 32'(ic_to_mc_en), 32'd0);
        check_val("arst_addr", ic_to_mc_addr, 32'd0);
        check_val("arst_iu_rdy", 32'(ic_to_iu_rdy), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b0;
        expect_miss(32'h4);
        expect_miss(32'h8C);
        expect_miss(32'h108);
        expect_miss(32'h300);
        tick();
        check_val("post_rst_en", 32'(ic_to_mc_en), 32'd1);
        check_val("post_rst_addr", ic_to_mc_addr, 32'h300);

        // 7: rdy_in low for 3 cycles before the third word
        fill_line(32'h300, 32'h6000_0000, 1'b1, 2, 4);
        expect_hit(32'h30C, 32'h6000_030C);
        expect_hit(32'h300, 32'h6000_0300);
        rdy_in = 1'b0;
        #1;
        check_val("rdy_low_hit", 32'(ic_to_iu_rdy), 32'd0);
        rdy_in = 1'b1;
        expect_miss(32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
